// File: rtl/pulp_clock_gating.sv
// Clock-gating cell: enable is latched while clk_i is low so the gated clock never chops a high phase.
// test_en_i bypasses the latch so DFT can force the clock through combinationally.
module pulp_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic r_en_lat;

    always_latch begin
        if (!clk_i) r_en_lat <= en_i;
    end

    assign clk_o = clk_i & (r_en_lat | test_en_i);

endmodule

// File: rtl/pulp_clock_mux2.sv
// Cell-based two-input clock mux; select changes must be aligned by the caller to avoid runts.
module pulp_clock_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);

    assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with a period-boundary ratio update handshake.
// Ratio 0/1 and testmode route clk_i through the gated clock-mux path.
module clk_div_prog #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             testmode_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_valid_i,
    output logic             div_ack_o,
    output logic             clk_o
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic             DEF_BYP = (DEFAULT_DIV <= 1);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_clk_div;
    logic             r_bypass;
    logic             r_run;
    logic             r_ack;

    logic [DIV_W-1:0] w_cnt_inc;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_boundary;
    logic             w_gated_clk;
    logic             w_sel;

    assign w_cnt_inc  = r_cnt + DIV_W'(1);
    assign w_boundary = r_bypass | ~r_run | (w_cnt_inc == r_div);
    assign w_div_nxt  = div_valid_i ? div_i : r_div;

    // Every ratio, enable and mode change lands only on a period boundary.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_div     <= DEF_DIV;
            r_cnt     <= '0;
            r_clk_div <= 1'b0;
            r_bypass  <= DEF_BYP;
            r_run     <= 1'b0;
            r_ack     <= 1'b0;
        end else if (w_boundary) begin
            r_run     <= en_i;
            r_cnt     <= '0;
            r_ack     <= div_valid_i;
            r_clk_div <= en_i & (w_div_nxt >= DIV_W'(2));
            if (div_valid_i) begin
                r_div    <= div_i;
                r_bypass <= (div_i <= DIV_W'(1));
            end
        end else begin
            r_cnt     <= w_cnt_inc;
            r_ack     <= 1'b0;
            r_clk_div <= (w_cnt_inc < (r_div >> 1));
        end
    end

    assign div_ack_o = r_ack;
    assign w_sel     = r_bypass | testmode_i;

    pulp_clock_gating u_icg (
        .clk_i     (clk_i),
        .en_i      (r_run),
        .test_en_i (testmode_i),
        .clk_o     (w_gated_clk)
    );

    pulp_clock_mux2 u_clk_mux (
        .clk0_i    (r_clk_div),
        .clk1_i    (w_gated_clk),
        .clk_sel_i (w_sel),
        .clk_o     (clk_o)
    );

    // A requester must hold valid and ratio steady until the boundary captures them.
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (div_valid_i && !w_boundary) |=> (div_valid_i && $stable(div_i)));

endmodule
